// File: rtl/fixed_pkg.sv
// ----------------------------------------------------------------------------
// fixed_pkg
// Shared definitions for the sign-magnitude fixed-point FMA blocks.
//   FX_N / FX_Q    default word width and fractional bit count
//   FX_SIGN        index of the sign bit in a word
//   FX_MAG_W       magnitude field width
//   FX_MAG_SAT     saturated (all ones) magnitude
//   state_t        fma_solve controller states
// ----------------------------------------------------------------------------
package fixed_pkg;

   localparam int FX_N     = 32;
   localparam int FX_Q     = 15;
   localparam int FX_SIGN  = FX_N - 1;
   localparam int FX_MAG_W = FX_N - 1;

   localparam logic [FX_MAG_W-1:0] FX_MAG_SAT = '1;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SUB  = 2'd1,
      ST_DIV  = 2'd2,
      ST_DONE = 2'd3
   } state_t;

endpackage

// File: rtl/fma_solve_if.sv
// ----------------------------------------------------------------------------
// fma_solve_if
// Operand/result handshake bundle for fma_solve.
//   i_valid/o_ready           operand handshake (y, a, b)
//   o_valid/i_ready           result handshake (result, ovr, dz)
// Modports: master = operand producer / result consumer, slave = fma_solve.
// ----------------------------------------------------------------------------
interface fma_solve_if
   import fixed_pkg::*;
   #(parameter int N = FX_N)
   ();

   logic         i_valid;
   logic         o_ready;
   logic [N-1:0] i_y;
   logic [N-1:0] i_a;
   logic [N-1:0] i_b;
   logic         o_valid;
   logic         i_ready;
   logic [N-1:0] o_result;
   logic         o_ovr;
   logic         o_dz;

   modport master (
      output i_valid, i_y, i_a, i_b, i_ready,
      input  o_ready, o_valid, o_result, o_ovr, o_dz
   );

   modport slave (
      input  i_valid, i_y, i_a, i_b, i_ready,
      output o_ready, o_valid, o_result, o_ovr, o_dz
   );

endinterface

// File: rtl/qdiv_core.sv
// ----------------------------------------------------------------------------
// qdiv_core
// Iterative unsigned restoring divider, one quotient bit per cycle, MSB first,
// N+Q iterations.
//   clk, rst_n   clock, asynchronous active-low reset
//   start        load dividend/divisor and clear the iteration counter
//   dividend     N+Q bit unsigned dividend
//   divisor      N bit unsigned divisor
//   done         high during the cycle whose edge performs the last iteration
//   quo_nxt      quotient as it will be after this cycle's iteration
// The caller captures quo_nxt while done is high, so the result is usable on
// the same edge that finishes the division.
// ----------------------------------------------------------------------------
module qdiv_core #(
   parameter int N = 32,
   parameter int Q = 15
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           start,
   input  logic [N+Q-1:0] dividend,
   input  logic [N-1:0]   divisor,
   output logic           done,
   output logic [N+Q-1:0] quo_nxt
);

   localparam int W  = N + Q;
   localparam int CW = $clog2(W + 1);

   logic          busy;
   logic [CW-1:0] cnt;
   logic [N-1:0]  rem;
   logic [W-1:0]  quo;
   logic [N:0]    rem_sh;
   logic [N:0]    trial;
   logic [N-1:0]  rem_nxt;

   // Remainder stays below the divisor, so N+1 bits hold the shifted value
   // and trial[N] is a clean borrow flag.
   always_comb begin
      rem_sh  = {rem, quo[W-1]};
      trial   = rem_sh - {1'b0, divisor};
      rem_nxt = trial[N] ? rem_sh[N-1:0] : trial[N-1:0];
      quo_nxt = {quo[W-2:0], ~trial[N]};
   end

   assign done = busy && (cnt == CW'(W - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy <= 1'b0;
         cnt  <= '0;
      end else if (start) begin
         busy <= 1'b1;
         cnt  <= '0;
      end else if (busy) begin
         cnt <= cnt + 1'b1;
         if (done) busy <= 1'b0;
      end
   end

   // quo doubles as the dividend shift register
   always_ff @(posedge clk) begin
      if (start) begin
         rem <= '0;
         quo <= dividend;
      end else if (busy) begin
         rem <= rem_nxt;
         quo <= quo_nxt;
      end
   end

endmodule

// File: rtl/fma_solve.sv
// ----------------------------------------------------------------------------
// fma_solve
// Sequential inverse of the sign-magnitude fixed-point FMA: recovers
// c = (y - a) / b in the same Q format, with saturation and flags.
//   i_clk, i_rst_n   clock, asynchronous active-low reset
//   bus (slave)      i_valid/o_ready + i_y, i_a, i_b operands;
//                    o_valid/i_ready + o_result, o_ovr, o_dz result
// Fixed latency: o_valid rises N+Q+1 edges after the accept edge.
// ----------------------------------------------------------------------------
module fma_solve
   import fixed_pkg::*;
   #(
   parameter int N = FX_N,
   parameter int Q = FX_Q
) (
   input  logic        i_clk,
   input  logic        i_rst_n,
   fma_solve_if.slave  bus
);

   typedef struct packed {
      logic         ovr;
      logic         dz;
      logic [N-1:0] word;
   } res_t;

   state_t         state;
   logic           ready_r;
   logic           valid_r;
   res_t           res_r;

   logic [N-1:0]   y_p0, a_p0, b_p0;
   logic           d_sgn_p1, d_zero_p1;

   logic [N-2:0]   y_mag, a_mag;
   logic [N-1:0]   d_mag;
   logic           d_sgn;
   logic           accept;
   logic           div_start;
   logic           div_done;
   logic [N+Q-1:0] quo_nxt;

   // Saturation and sign rules; divide-by-zero outranks overflow and keeps
   // the sign of d rather than the quotient sign.
   function automatic res_t resolve(input logic [N+Q-1:0] quo,
                                    input logic           dsgn,
                                    input logic           dzero,
                                    input logic           bsgn,
                                    input logic           bzero);
      res_t         r;
      logic [N-2:0] mag;
      logic         sgn;
      r.ovr = 1'b0;
      r.dz  = 1'b0;
      if (bzero) begin
         r.dz = 1'b1;
         mag  = dzero ? '0 : '1;
         sgn  = dsgn;
      end else if (|quo[N+Q-1:N-1]) begin
         r.ovr = 1'b1;
         mag   = '1;
         sgn   = dsgn ^ bsgn;
      end else begin
         mag = quo[N-2:0];
         sgn = dsgn ^ bsgn;
      end
      if (mag == '0) sgn = 1'b0;
      r.word = {sgn, mag};
      return r;
   endfunction

   assign accept    = (state == ST_IDLE) && bus.i_valid;
   assign div_start = (state == ST_SUB);

   // Stage p0 -> p1: y - a with one extra magnitude bit so it cannot overflow
   assign y_mag = y_p0[N-2:0];
   assign a_mag = a_p0[N-2:0];

   always_comb begin
      if (y_p0[N-1] != a_p0[N-1]) begin
         d_mag = {1'b0, y_mag} + {1'b0, a_mag};
         d_sgn = y_p0[N-1];
      end else if (y_mag >= a_mag) begin
         d_mag = {1'b0, y_mag - a_mag};
         d_sgn = y_p0[N-1];
      end else begin
         d_mag = {1'b0, a_mag - y_mag};
         d_sgn = ~y_p0[N-1];
      end
      if (d_mag == '0) d_sgn = 1'b0;
   end

   always_ff @(posedge i_clk) begin
      if (accept) begin
         y_p0 <= bus.i_y;
         a_p0 <= bus.i_a;
         b_p0 <= bus.i_b;
      end
      if (div_start) begin
         d_sgn_p1  <= d_sgn;
         d_zero_p1 <= (d_mag == '0);
      end
   end

   // Stage p1 -> divider: |d| << Q over |b|
   qdiv_core #(.N(N), .Q(Q)) u_div (
      .clk      (i_clk),
      .rst_n    (i_rst_n),
      .start    (div_start),
      .dividend ({d_mag, {Q{1'b0}}}),
      .divisor  ({1'b0, b_p0[N-2:0]}),
      .done     (div_done),
      .quo_nxt  (quo_nxt)
   );

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state   <= ST_IDLE;
         ready_r <= 1'b1;
         valid_r <= 1'b0;
         res_r   <= '0;
      end else begin
         case (state)
            ST_IDLE: if (bus.i_valid) begin
               state   <= ST_SUB;
               ready_r <= 1'b0;
            end
            ST_SUB: state <= ST_DIV;
            ST_DIV: if (div_done) begin
               state   <= ST_DONE;
               valid_r <= 1'b1;
               res_r   <= resolve(quo_nxt, d_sgn_p1, d_zero_p1,
                                  b_p0[N-1], b_p0[N-2:0] == '0);
            end
            ST_DONE: if (bus.i_ready) begin
               state   <= ST_IDLE;
               valid_r <= 1'b0;
               ready_r <= 1'b1;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   assign bus.o_ready  = ready_r;
   assign bus.o_valid  = valid_r;
   assign bus.o_result = res_r.word;
   assign bus.o_ovr    = res_r.ovr;
   assign bus.o_dz     = res_r.dz;

endmodule

// File: tb/tb_fma_solve.sv
// ----------------------------------------------------------------------------
// tb_fma_solve
// Self-checking bench for fma_solve: directed cases, handshake hold/release,
// reset in the middle of the division, and randomized operands against an
// integer-arithmetic reference model.
// ----------------------------------------------------------------------------
module tb_fma_solve;
   import fixed_pkg::*;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   always #5 clk = ~clk;

   fma_solve_if bus ();

   fma_solve dut (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .bus     (bus)
   );

   int n_chk  = 0;
   int n_fail = 0;

   task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, want %0h", tag, act, exp);
      end
   endtask

   // Reference: signed integer values, exact division, then saturation.
   // Returns {ovr, dz, result_word}.
   function automatic logic [33:0] model(input logic [31:0] y, input logic [31:0] a,
                                         input logic [31:0] b);
      longint       yv, av, d, dm, bm, q;
      logic         s, ovr, dz;
      logic [30:0]  mag;
      yv  = y[31] ? -longint'(y[30:0]) : longint'(y[30:0]);
      av  = a[31] ? -longint'(a[30:0]) : longint'(a[30:0]);
      d   = yv - av;
      dm  = (d < 0) ? -d : d;
      bm  = longint'(b[30:0]);
      ovr = 1'b0;
      dz  = 1'b0;
      if (bm == 0) begin
         dz  = 1'b1;
         mag = (dm == 0) ? 31'd0 : FX_MAG_SAT;
         s   = (d < 0);
      end else begin
         q = (dm * 32768) / bm;
         if (q > 64'h7FFF_FFFF) begin
            ovr = 1'b1;
            mag = FX_MAG_SAT;
         end else begin
            mag = q[30:0];
         end
         s = (d < 0) ^ b[31];
      end
      if (mag == 31'd0) s = 1'b0;
      return {ovr, dz, s, mag};
   endfunction

   function automatic logic [31:0] rnd_word();
      logic [31:0] w;
      w = $urandom;
      case ($urandom_range(0, 4))
         0: w[30:0] = w[30:0] >> $urandom_range(0, 30);
         1: w[30:0] = {15'd0, w[15:0]};
         2: w[30:0] = {7'd0, w[23:0]};
         3: if ($urandom_range(0, 3) == 0) w[30:0] = '0;
         default: ;
      endcase
      return w;
   endfunction

   // Called at posedge+1 with the DUT idle. Checks ready drop, latency,
   // result/flags, stability while i_ready is held low (with ignored i_valid
   // pulses), and ready return after release.
   task automatic run_op(input string tag, input logic [31:0] y, input logic [31:0] a,
                         input logic [31:0] b, input logic [33:0] exp, input int hold);
      int lat;
      bit got;
      bus.i_y     = y;
      bus.i_a     = a;
      bus.i_b     = b;
      bus.i_valid = 1'b1;
      @(posedge clk);
      #1;
      bus.i_valid = 1'b0;
      check({tag, "/ready_drop"}, bus.o_ready, 1'b0);
      lat = 0;
      got = 1'b0;
      while (!got && lat < 200) begin
         @(posedge clk);
         #1;
         lat++;
         if (bus.o_valid) got = 1'b1;
      end
      check({tag, "/latency"}, lat, 48);
      check({tag, "/result"}, {bus.o_ovr, bus.o_dz, bus.o_result}, exp);
      for (int i = 0; i < hold; i++) begin
         bus.i_valid = 1'b1;
         bus.i_y     = $urandom;
         bus.i_a     = $urandom;
         bus.i_b     = $urandom;
         @(posedge clk);
         #1;
         check({tag, "/hold"}, {bus.o_valid, bus.o_ready, bus.o_ovr, bus.o_dz, bus.o_result},
               {1'b1, 1'b0, exp});
      end
      bus.i_valid = 1'b0;
      bus.i_ready = 1'b1;
      @(posedge clk);
      #1;
      bus.i_ready = 1'b0;
      check({tag, "/release"}, {bus.o_valid, bus.o_ready}, 2'b01);
   endtask

   initial begin
      logic [31:0] ry, ra, rb;
      bus.i_valid = 1'b0;
      bus.i_ready = 1'b0;
      bus.i_y     = '0;
      bus.i_a     = '0;
      bus.i_b     = '0;

      repeat (2) @(posedge clk);
      #1;
      check("reset_state", {bus.o_ready, bus.o_valid, bus.o_ovr, bus.o_dz, bus.o_result},
            {1'b1, 1'b0, 1'b0, 1'b0, 32'h0});
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      run_op("basic_7m1d2",  32'h0003_8000, 32'h0000_8000, 32'h0001_0000,
             {2'b00, 32'h0001_8000}, 0);
      run_op("neg_divisor",  32'h0003_0000, 32'h0000_0000, 32'h8001_0000,
             {2'b00, 32'h8001_8000}, 0);
      run_op("div_zero",     32'h0000_8000, 32'h0000_0000, 32'h0000_0000,
             {2'b01, 32'h7FFF_FFFF}, 0);
      run_op("div_zero_neg", 32'h8000_8000, 32'h0000_0000, 32'h8000_0000,
             {2'b01, 32'hFFFF_FFFF}, 0);
      run_op("zero_by_zero", 32'h0000_0005, 32'h0000_0005, 32'h0000_0000,
             {2'b01, 32'h0000_0000}, 0);
      run_op("overflow",     32'h4000_0000, 32'h0000_0000, 32'h0000_0001,
             {2'b10, 32'h7FFF_FFFF}, 0);
      run_op("pos_zero",     32'h8000_8000, 32'h8000_8000, 32'h0001_0000,
             {2'b00, 32'h0000_0000}, 0);
      run_op("hold_ready",   32'h0003_8000, 32'h0000_8000, 32'h0001_0000,
             {2'b00, 32'h0001_8000}, 10);

      // Reset after 20 division iterations (edges 2..21 after accept)
      bus.i_y     = 32'h0003_8000;
      bus.i_a     = 32'h0000_8000;
      bus.i_b     = 32'h0001_0000;
      bus.i_valid = 1'b1;
      @(posedge clk);
      #1;
      bus.i_valid = 1'b0;
      repeat (21) @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check("mid_div_reset", {bus.o_ready, bus.o_valid, bus.o_ovr, bus.o_dz, bus.o_result},
            {1'b1, 1'b0, 1'b0, 1'b0, 32'h0});
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      run_op("after_reset",  32'h0003_0000, 32'h0000_0000, 32'h8001_0000,
             {2'b00, 32'h8001_8000}, 0);

      for (int i = 0; i < 30; i++) begin
         ry = rnd_word();
         ra = rnd_word();
         rb = rnd_word();
         run_op("random", ry, ra, rb, model(ry, ra, rb), $urandom_range(0, 2));
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end

endmodule
